wb_bypass_pipe: RTL and testbench
=================================

Name: wb_bypass_pipe

Overview:
- Parametrised writeback pipeline that replaces the fixed EX→MEM→WB register chain in the core top.
- Carries register-write records (we, waddr, wdata) through DEPTH stages and drives the regfile write port from the last stage.
- Resolves RAW hazards with a bypass network for NRD read ports, newest in-flight producer first, regfile data last.
- Supports stall and flush, so Id no longer reads stale regfile data.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; address 0 is the hard-wired zero register.
- DEPTH, 3, number of in-flight stages (legal range 2..8).
- NRD, 2, number of bypassed read ports.
- LOAD_STAGE, 1, stage index at which load data is merged (only with the optional feature; must be < DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  hold stage 0 and inject a bubble into stage 1.
- flush_i  in  1  invalidate stage 0 and drop the incoming record.
- in_valid_i  in  1  a new record is presented.
- in_we_i  in  1  record writes a register.
- in_waddr_i  in  ADDR_W  destination register.
- in_wdata_i  in  DATA_W  result data.
- in_ld_i  in  1  data arrives later from memory (feature only).
- mem_rdata_i  in  DATA_W  load data for the entry at LOAD_STAGE (feature only).
- rd_addr_i  in  NRD*ADDR_W  read addresses; port k uses [k*ADDR_W +: ADDR_W].
- rf_rdata_i  in  NRD*DATA_W  raw regfile read data.
- rd_data_o  out  NRD*DATA_W  bypassed operand data.
- stall_req_o  out  1  load-use hazard; the Id stage must stall.
- rf_we_o  out  1  regfile write enable.
- rf_waddr_o  out  ADDR_W  regfile write address.
- rf_wdata_o  out  DATA_W  regfile write data.

Behaviour:
- **Entry fields:** valid, we, waddr, wdata, rdy.
- **Reset:** rst=1 at a clk edge clears valid/we/rdy in all stages, and waddr/wdata to 0.
  - Outputs after reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, stall_req_o=0.
  - Reset overrides stall_i and flush_i; a reset mid-stream drops all in-flight records.
- **Advance:** stages 1..DEPTH-1 shift every cycle (stage i ← stage i-1).
- **Stage 0 priority:**
  - flush_i: stage 0 ← invalid. flush_i has priority over stall_i; flush with stall still pushes a bubble into stage 1.
  - else stall_i: stage 0 holds and stage 1 ← bubble.
  - else: stage 0 ← input.
- **Input capture:** valid=in_valid_i, we=in_we_i & (in_waddr_i!=0), rdy=~in_ld_i (rdy=1 without the feature).
- **Regfile write:** rf_we_o = valid & we of stage DEPTH-1; waddr/wdata come straight from that stage. Total latency from capture to regfile write = DEPTH cycles with no stall.
- **Bypass (combinational), per port k with address a:**
  - a==0 → output 0.
  - Otherwise scan stages 0..DEPTH-1; the first stage with valid & we & waddr==a wins.
  - No match → rf_rdata_i[k].
  - Stage DEPTH-1 is included, so the regfile needs no internal write-through.
- **Hazard:** a winning entry with rdy=0 asserts stall_req_o=1, and that port's output is 0. Older matches never mask a younger not-ready one.
- Simultaneous hits on all ports are resolved independently per port.

Optional Feature:
- **Macro:** WB_BYPASS_LOAD_EN
- **Defined:**
  - in_ld_i and mem_rdata_i are active.
  - When the entry entering stage LOAD_STAGE has rdy=0, it captures wdata←mem_rdata_i and rdy←1 on that edge.
  - Bypass hits on rdy=0 entries raise stall_req_o.
- **Undefined:**
  - in_ld_i and mem_rdata_i are ignored.
  - rdy is constant 1 and stall_req_o is tied to 0.
  - No rdy flops are synthesised.

Decomposition:
- Shared defines file gets: WB_DEPTH_MAX=8; the record field widths (reuse the existing register-address and data-width macros); the zero-register address constant.
- Natural sub-module: wb_bypass_stage.
  - One registered entry with reset, load-enable and bubble-insert.
  - Instantiated DEPTH times via generate.
- Bypass priority mux stays in the parent.

Test Plan:
- **Reset/latency:** reset, then write (we=1, waddr=3, wdata=0x11) → rf_we_o=1 with waddr 3 and data 0x11 exactly 3 cycles later; all outputs 0 during reset.
- **Priority:** back-to-back writes r5=0xA then r5=0xB, read r5 → 0xB while both are in flight, 0xA never visible; after drain, rf_rdata_i is passed through.
- **Zero register:** write r0=0xFFFF, read r0 → rd_data_o=0 and rf_we_o=0.
- **Stall/flush:**
  - stall_i for 2 cycles with r7=0x7 in stage 0 → r7 write delayed 2 cycles.
  - flush_i the same cycle → r7 never written and no bypass hit.
- **Load-use (feature on):** load r9 with in_ld_i=1, read r9 next cycle → stall_req_o=1; once the entry passes LOAD_STAGE with mem_rdata_i=0xDEAD → stall_req_o=0 and rd_data_o=0xDEAD.
- **Reset mid-stream:** 3 records in flight, pulse rst → no rf write occurs and reads return rf_rdata_i.

Source files
------------

// File: rtl/wb_bypass_pipe_pkg.sv
// ---------------------------------------------------------------------------
// wb_bypass_pipe_pkg : shared constants for the writeback bypass pipeline
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_bypass_pipe_pkg;

  localparam int WB_DEPTH_MAX = 8;
  localparam int WB_DEPTH_MIN = 2;
  localparam int WB_DATA_W    = 32;
  localparam int WB_ADDR_W    = 5;
  localparam int WB_ZERO_ADDR = 0;

endpackage

`default_nettype wire

// File: rtl/wb_bypass_stage.sv
// ---------------------------------------------------------------------------
// wb_bypass_stage : one registered writeback record with load-enable and bubble
// Rev 1.0  (rdy flop only exists when WB_BYPASS_LOAD_EN is defined)
// ---------------------------------------------------------------------------
`default_nettype none

module wb_bypass_stage
  import wb_bypass_pipe_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              bubble,
`ifdef WB_BYPASS_LOAD_EN
  input  logic              d_rdy,
  output logic              q_rdy,
`endif
  input  logic              d_valid,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              q_valid,
  output logic              q_we,
  output logic [ADDR_W-1:0] q_waddr,
  output logic [DATA_W-1:0] q_wdata
);

  // A bubble only kills valid/we; stale address/data are harmless behind them.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_we    <= 1'b0;
      q_waddr <= '0;
      q_wdata <= '0;
`ifdef WB_BYPASS_LOAD_EN
      q_rdy   <= 1'b0;
`endif
    end else if (bubble) begin
      q_valid <= 1'b0;
      q_we    <= 1'b0;
    end else if (load_en) begin
      q_valid <= d_valid;
      q_we    <= d_we;
      q_waddr <= d_waddr;
      q_wdata <= d_wdata;
`ifdef WB_BYPASS_LOAD_EN
      q_rdy   <= d_rdy;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_bypass_pipe.sv
// ---------------------------------------------------------------------------
// wb_bypass_pipe : DEPTH-stage writeback pipe with youngest-first RAW bypass
// Rev 1.0  (optional late load data merge: WB_BYPASS_LOAD_EN)
// ---------------------------------------------------------------------------
`default_nettype none

module wb_bypass_pipe
  import wb_bypass_pipe_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DEPTH      = 3,
  parameter int NRD        = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  input  logic                  in_we_i,
  input  logic [ADDR_W-1:0]     in_waddr_i,
  input  logic [DATA_W-1:0]     in_wdata_i,
  input  logic                  in_ld_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  input  logic [NRD*DATA_W-1:0] rf_rdata_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic                  stall_req_o,
  output logic                  rf_we_o,
  output logic [ADDR_W-1:0]     rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(WB_ZERO_ADDR);

  logic [DEPTH-1:0]  s_valid;
  logic [DEPTH-1:0]  s_we;
  logic [ADDR_W-1:0] s_waddr [DEPTH];
  logic [DATA_W-1:0] s_wdata [DEPTH];
`ifdef WB_BYPASS_LOAD_EN
  logic [DEPTH-1:0]  s_rdy;
`else
  logic unused_load_inputs;
  assign unused_load_inputs = ^{in_ld_i, mem_rdata_i, (LOAD_STAGE < DEPTH)};
`endif

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic              d_valid;
      logic              d_we;
      logic [ADDR_W-1:0] d_waddr;
      logic [DATA_W-1:0] d_wdata_raw;
      logic [DATA_W-1:0] d_wdata;
      logic              ld_en;
      logic              bub;
`ifdef WB_BYPASS_LOAD_EN
      logic              d_rdy_raw;
      logic              d_rdy;
`endif

      if (i == 0) begin : g_head
        assign d_valid     = in_valid_i;
        assign d_we        = in_we_i & (in_waddr_i != ZERO_ADDR);
        assign d_waddr     = in_waddr_i;
        assign d_wdata_raw = in_wdata_i;
        assign ld_en       = ~stall_i;
        assign bub         = flush_i;
`ifdef WB_BYPASS_LOAD_EN
        assign d_rdy_raw   = ~in_ld_i;
`endif
      end else begin : g_body
        assign d_valid     = s_valid[i-1];
        assign d_we        = s_we[i-1];
        assign d_waddr     = s_waddr[i-1];
        assign d_wdata_raw = s_wdata[i-1];
        assign ld_en       = 1'b1;
        // Stage 0 is either held (stall) or killed (flush): stage 1 sees a bubble.
        assign bub         = (i == 1) ? (stall_i | flush_i) : 1'b0;
`ifdef WB_BYPASS_LOAD_EN
        assign d_rdy_raw   = s_rdy[i-1];
`endif
      end

`ifdef WB_BYPASS_LOAD_EN
      if (i == LOAD_STAGE) begin : g_merge
        assign d_wdata = d_rdy_raw ? d_wdata_raw : mem_rdata_i;
        assign d_rdy   = 1'b1;
      end else begin : g_pass
        assign d_wdata = d_wdata_raw;
        assign d_rdy   = d_rdy_raw;
      end
`else
      assign d_wdata = d_wdata_raw;
`endif

      wb_bypass_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_stage (
        .clk     (clk),
        .rst     (rst),
        .load_en (ld_en),
        .bubble  (bub),
`ifdef WB_BYPASS_LOAD_EN
        .d_rdy   (d_rdy),
        .q_rdy   (s_rdy[i]),
`endif
        .d_valid (d_valid),
        .d_we    (d_we),
        .d_waddr (d_waddr),
        .d_wdata (d_wdata),
        .q_valid (s_valid[i]),
        .q_we    (s_we[i]),
        .q_waddr (s_waddr[i]),
        .q_wdata (s_wdata[i])
      );
    end
  endgenerate

  assign rf_we_o    = s_valid[DEPTH-1] & s_we[DEPTH-1];
  assign rf_waddr_o = s_waddr[DEPTH-1];
  assign rf_wdata_o = s_wdata[DEPTH-1];

  logic [ADDR_W-1:0] byp_addr;
  logic [DATA_W-1:0] byp_data;
`ifdef WB_BYPASS_LOAD_EN
  logic              byp_pend;
  logic              byp_hazard;
`endif

  // Scan oldest to youngest so the youngest matching producer is the last write.
  always_comb begin
    rd_data_o  = '0;
    byp_addr   = '0;
    byp_data   = '0;
`ifdef WB_BYPASS_LOAD_EN
    byp_pend   = 1'b0;
    byp_hazard = 1'b0;
`endif
    for (int k = 0; k < NRD; k++) begin
      byp_addr = rd_addr_i[k*ADDR_W +: ADDR_W];
      byp_data = rf_rdata_i[k*DATA_W +: DATA_W];
`ifdef WB_BYPASS_LOAD_EN
      byp_pend = 1'b0;
`endif
      if (byp_addr == ZERO_ADDR) begin
        byp_data = '0;
      end else begin
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (s_valid[i] && s_we[i] && (s_waddr[i] == byp_addr)) begin
            byp_data = s_wdata[i];
`ifdef WB_BYPASS_LOAD_EN
            byp_pend = ~s_rdy[i];
`endif
          end
        end
      end
`ifdef WB_BYPASS_LOAD_EN
      if (byp_pend) byp_data = '0;
      byp_hazard = byp_hazard | byp_pend;
`endif
      rd_data_o[k*DATA_W +: DATA_W] = byp_data;
    end
  end

`ifdef WB_BYPASS_LOAD_EN
  assign stall_req_o = byp_hazard;
`else
  assign stall_req_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_bypass_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_bypass_pipe : directed + random bench against an in-flight record model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_bypass_pipe;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 3;
  localparam int NRD        = 2;
  localparam int LOAD_STAGE = 1;

  logic                  clk;
  logic                  rst;
  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic                  in_we;
  logic [ADDR_W-1:0]     in_waddr;
  logic [DATA_W-1:0]     in_wdata;
  logic                  in_ld;
  logic [DATA_W-1:0]     mem_rdata;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rf_rdata;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  stall_req;
  logic                  rf_we;
  logic [ADDR_W-1:0]     rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;

  int total = 0;
  int bad   = 0;

  wb_bypass_pipe #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .NRD        (NRD),
    .LOAD_STAGE (LOAD_STAGE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_we_i     (in_we),
    .in_waddr_i  (in_waddr),
    .in_wdata_i  (in_wdata),
    .in_ld_i     (in_ld),
    .mem_rdata_i (mem_rdata),
    .rd_addr_i   (rd_addr),
    .rf_rdata_i  (rf_rdata),
    .rd_data_o   (rd_data),
    .stall_req_o (stall_req),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: every in-flight record carries its current pipeline position.
  typedef struct {
    int              pos;
    bit              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit              rdy;
  } rec_t;

  rec_t q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string ctx);
    bit                exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    bit                exp_hz;
    exp_we = 0; exp_addr = '0; exp_data = '0; exp_hz = 0;
    foreach (q[j]) begin
      if (q[j].pos == DEPTH - 1 && q[j].we) begin
        exp_we = 1; exp_addr = q[j].addr; exp_data = q[j].data;
      end
    end
    check({ctx, " rf_we"}, 64'(rf_we), 64'(exp_we));
    if (exp_we) begin
      check({ctx, " rf_waddr"}, 64'(rf_waddr), 64'(exp_addr));
      check({ctx, " rf_wdata"}, 64'(rf_wdata), 64'(exp_data));
    end
    for (int k = 0; k < NRD; k++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] e;
      int best;
      bit best_rdy;
      a = rd_addr[k*ADDR_W +: ADDR_W];
      e = rf_rdata[k*DATA_W +: DATA_W];
      best = DEPTH;
      best_rdy = 1;
      if (a == 0) e = '0;
      else begin
        foreach (q[j]) begin
          if (q[j].we && q[j].addr == a && q[j].pos < best) begin
            best = q[j].pos; best_rdy = q[j].rdy;
            e = q[j].rdy ? q[j].data : '0;
          end
        end
      end
      if (best < DEPTH && !best_rdy) exp_hz = 1;
      check($sformatf("%s rd%0d", ctx, k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(e));
    end
    check({ctx, " stall_req"}, 64'(stall_req), 64'(exp_hz));
  endtask

  task automatic update_model();
    rec_t nq[$];
    rec_t r;
`ifdef WB_BYPASS_LOAD_EN
    bit moved;
`endif
    if (rst) begin
      q.delete();
      return;
    end
    foreach (q[j]) begin
      r = q[j];
`ifdef WB_BYPASS_LOAD_EN
      moved = 1;
`endif
      if (r.pos == 0) begin
        if (flush) continue;
        else if (stall) begin
`ifdef WB_BYPASS_LOAD_EN
          moved = 0;
`endif
        end else r.pos = 1;
      end else r.pos++;
      if (r.pos >= DEPTH) continue;
`ifdef WB_BYPASS_LOAD_EN
      if (moved && r.pos == LOAD_STAGE && !r.rdy) begin
        r.data = mem_rdata; r.rdy = 1;
      end
`endif
      nq.push_back(r);
    end
    if (!flush && !stall && in_valid) begin
      r.pos  = 0;
      r.we   = in_we && (in_waddr != 0);
      r.addr = in_waddr;
      r.data = in_wdata;
`ifdef WB_BYPASS_LOAD_EN
      r.rdy  = !in_ld;
      if (LOAD_STAGE == 0 && !r.rdy) begin
        r.data = mem_rdata; r.rdy = 1;
      end
`else
      r.rdy  = 1;
`endif
      nq.push_back(r);
    end
    q = nq;
  endtask

  // Called right after a negedge with inputs already driven.
  task automatic step(input string ctx);
    #1;
    check_model(ctx);
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; in_valid = 0; in_we = 0; in_ld = 0;
    in_waddr = '0; in_wdata = '0; mem_rdata = '0;
  endtask

  task automatic put(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1; in_we = 1; in_waddr = a; in_wdata = d; in_ld = 0;
  endtask

  initial begin
    idle();
    rd_addr = '0; rf_rdata = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    q.delete();
    @(negedge clk);
    #1;
    check("reset rf_we", 64'(rf_we), 64'd0);
    check("reset rf_waddr", 64'(rf_waddr), 64'd0);
    check("reset rf_wdata", 64'(rf_wdata), 64'd0);
    check("reset stall_req", 64'(stall_req), 64'd0);
    check("reset rd_data", 64'(rd_data), 64'd0);
    idle();

    // Latency: capture to regfile write in DEPTH cycles.
    put(5'd3, 32'h11);
    step("lat0");
    idle();
    step("lat1");
    #1 check("lat early rf_we", 64'(rf_we), 64'd0);
    step("lat2");
    #1;
    check("lat rf_we", 64'(rf_we), 64'd1);
    check("lat rf_waddr", 64'(rf_waddr), 64'd3);
    check("lat rf_wdata", 64'(rf_wdata), 64'h11);
    step("lat3");

    // Youngest producer wins.
    put(5'd5, 32'hA);
    step("pri0");
    put(5'd5, 32'hB);
    step("pri1");
    idle();
    rd_addr = {5'd5, 5'd5};
    rf_rdata = {32'h5555, 32'h5555};
    #1 check("pri young", 64'(rd_data[DATA_W-1:0]), 64'hB);
    repeat (4) step("pri drain");
    #1 check("pri drained", 64'(rd_data[DATA_W-1:0]), 64'h5555);

    // Zero register is never written nor bypassed.
    put(5'd0, 32'hFFFF);
    rd_addr = '0;
    rf_rdata = {32'h1234, 32'h5678};
    step("zero0");
    idle();
    step("zero1");
    step("zero2");
    #1;
    check("zero rf_we", 64'(rf_we), 64'd0);
    check("zero rd", 64'(rd_data), 64'd0);

    // Two stall cycles delay the r7 write by two cycles.
    put(5'd7, 32'h7);
    step("stall0");
    idle();
    stall = 1;
    step("stall1");
    step("stall2");
    stall = 0;
    step("stall3");
    #1 check("stall early rf_we", 64'(rf_we), 64'd0);
    step("stall4");
    #1;
    check("stall rf_we", 64'(rf_we), 64'd1);
    check("stall rf_waddr", 64'(rf_waddr), 64'd7);
    step("stall5");

    // Flush drops r7 sitting in stage 0.
    put(5'd7, 32'h77);
    step("flush0");
    idle();
    flush = 1;
    rd_addr = {5'd0, 5'd7};
    rf_rdata = {32'h0, 32'h1234};
    step("flush1");
    flush = 0;
    #1 check("flush no hit", 64'(rd_data[DATA_W-1:0]), 64'h1234);
    for (int c = 0; c < 3; c++) begin
      #1 check("flush rf_we", 64'(rf_we), 64'd0);
      step("flush drain");
    end

`ifdef WB_BYPASS_LOAD_EN
    // Load-use: stall until the data is merged at LOAD_STAGE.
    in_valid = 1; in_we = 1; in_waddr = 5'd9; in_wdata = 32'h0BAD; in_ld = 1;
    step("ld0");
    idle();
    rd_addr = {5'd0, 5'd9};
    mem_rdata = 32'hDEAD;
    #1;
    check("ld stall_req", 64'(stall_req), 64'd1);
    check("ld rd hidden", 64'(rd_data[DATA_W-1:0]), 64'd0);
    step("ld1");
    idle();
    #1;
    check("ld stall_req clear", 64'(stall_req), 64'd0);
    check("ld rd merged", 64'(rd_data[DATA_W-1:0]), 64'hDEAD);
    repeat (3) step("ld drain");
`endif

    // Reset mid-stream drops every in-flight record.
    put(5'd1, 32'h101);
    rd_addr = {5'd2, 5'd1};
    rf_rdata = {32'hAAA2, 32'hAAA1};
    step("mid0");
    put(5'd2, 32'h202);
    step("mid1");
    put(5'd3, 32'h303);
    rst = 1;
    step("mid2");
    idle();
    for (int c = 0; c < 4; c++) begin
      #1;
      check("mid rf_we", 64'(rf_we), 64'd0);
      check("mid rd", 64'(rd_data), {32'hAAA2, 32'hAAA1});
      step("mid drain");
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom % 64) == 0;
      stall     = ($urandom % 8) == 0;
      flush     = ($urandom % 16) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_we     = ($urandom % 4) != 0;
      in_ld     = ($urandom % 4) == 0;
      in_waddr  = ADDR_W'($urandom % 8);
      in_wdata  = $urandom;
      mem_rdata = $urandom;
      rd_addr   = {ADDR_W'($urandom % 8), ADDR_W'($urandom % 8)};
      rf_rdata  = {$urandom, $urandom};
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
